// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) is stepped
// LSB-first over WIDTH cycles, result reported with a one-cycle done pulse.

module halfadd (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic p, g1, s, g2, c_next;

   halfadd u_ha1 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(p), .c_o(g1));
   halfadd u_ha2 (.a_i(p),      .b_i(c_q),    .s_o(s), .c_o(g2));
   assign c_next = g1 | g2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_d     = c_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               c_d     = cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d = {s, sum_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_next;
            cnt_d = cnt_q + CW'(1);
            // cout latches the final carry so it holds through IDLE
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               cout_d  = c_next;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table,
// random operands against an arithmetic model, and multi-cycle corner cases.

module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b;
   logic [W-1:0] sum;
   logic         cout, busy, done;

   int n_chk  = 0;
   int n_pass = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // advance one clock; inputs are driven and outputs sampled at negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] es, input logic ec);
      a = va; b = vb; cin = vc; start = 1'b1;
      step();
      start = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      for (int k = 1; k <= W + 1; k++) begin
         chk("busy_run", busy, 1);
         chk("done_timing", done, (k == W + 1));
         if (k == W + 1) begin
            chk("sum", sum, es);
            chk("cout", cout, ec);
         end
         step();
      end
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
      chk("sum_hold", sum, es);
      chk("cout_hold", cout, ec);
   endtask

   initial begin
      logic [W:0] model;
      logic [W-1:0] ra, rb;
      logic rc;
      int ndone;

      vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
      vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, co: 1'b0};
      vecs[3] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, co: 1'b1};
      vecs[4] = '{a: 8'h12, b: 8'h34, cin: 1'b1, s: 8'h47, co: 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      step(); step();
      // rst dominates start
      start = 1'b1; a = 8'h11; b = 8'h22;
      step();
      start = 1'b0;
      rst = 1'b0;
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      step();
      chk("rst_busy2", busy, 0);

      for (int i = 0; i < 5; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         model = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
         run_op(ra, rb, rc, model[W-1:0], model[W]);
      end

      // start while busy is ignored
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 3) begin
            start = 1'b1; a = 8'hFF; b = 8'hFF;
         end else begin
            start = 1'b0;
         end
         if (done) ndone++;
         if (k == W + 1) begin
            chk("rej_done", done, 1);
            chk("rej_sum", sum, 8'h30);
            chk("rej_cout", cout, 0);
         end
         if (k > W + 1) chk("rej_no_restart", busy, 0);
         step();
      end
      chk("rej_done_count", ndone, 1);

      // reset mid-run aborts without a done pulse
      a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) ndone++;
         step();
      end
      chk("abort_quiet", ndone, 0);
      run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

      // start held high: one operation per W+2 cycles
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      step();
      for (int k = 1; k <= 29; k++) begin
         chk("b2b_done", done, (k == 9 || k == 19 || k == 29));
         chk("b2b_busy", busy, (k != 10 && k != 20));
         if (done) begin
            chk("b2b_sum", sum, 8'h02);
            chk("b2b_cout", cout, 0);
         end
         if (k == 29) start = 1'b0;
         step();
      end
      chk("b2b_end_idle", busy, 0);
      step();
      chk("b2b_no_restart", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit adder slice over WIDTH cycles to add two WIDTH-bit operands. The adder slice is built from two `halfadd` instances plus an OR for the carry. The block captures the operands on a start request, feeds them LSB-first through the slice, and accumulates the sum in a shift register. It then reports the result with a one-cycle done pulse. It sits between a requester (lab top level or testbench) and the `halfadd` datapath, trading area for latency.

## Interface

- WIDTH, default 8: operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in, captured on the accepted start.
- sum  output  WIDTH  result register, LSB = bit 0.
- cout  output  1  carry-out of bit WIDTH-1.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.

## Operation

- States: IDLE, RUN, DONE. Encoding is free. Outputs are registered or decoded from registered state only.
- Internal registers:
  - a_sr and b_sr, WIDTH-bit operand shift registers.
  - c, a 1-bit carry flop.
  - cnt, a bit counter of width clog2(WIDTH).
  - sum_sr, which drives sum.
- Slice datapath:
  - halfadd #1 computes (a_sr[0], b_sr[0]) -> (p, g1).
  - halfadd #2 computes (p, c) -> (s, g2).
  - The carry is c_next = g1 | g2.
- IDLE to RUN: on start=1, capture a_sr<=a, b_sr<=b, c<=cin, cnt<=0. Clear sum_sr and cout.
- RUN, on each edge:
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right with zero fill.
  - c <= c_next.
  - cnt <= cnt+1.
- RUN to DONE: on the edge where cnt == WIDTH-1, after that edge's shift. At this point the full sum is in sum_sr and the final carry is in c.
- cout is driven from c. It is meaningful only when done=1 or afterwards in IDLE.
- DONE: done=1 for exactly one cycle, then unconditional transition to IDLE.
- Holding the result: sum and cout keep the last result in IDLE until the next accepted start clears them.
- start while busy (RUN or DONE) is ignored. Operands are not re-captured and no request is queued.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag; signed interpretation is the requester's job.

## Timing

- Reset values: state=IDLE, sum=0, cout=0, busy=0, done=0. All internal registers are 0.
- rst dominates start on the same edge.
- Reset in any state (including mid-RUN) aborts the operation. There is no done pulse and outputs go to reset values on the next cycle.
- Cycle numbering: cycle 0 is when start=1 is sampled in IDLE.
  - Cycles 1..WIDTH: RUN, busy=1.
  - Cycle WIDTH+1: DONE, busy=1, done=1, and sum/cout are final.
  - Cycle WIDTH+2: IDLE, busy=0. A new start can be accepted here.
- Latency from start to done is WIDTH+1 cycles.
- Throughput with start held high is one operation per WIDTH+2 cycles.
- sum bits change during RUN and must not be consumed before done.
- cnt wrap: cnt never exceeds WIDTH-1. It is reloaded on every accepted start.

## Test plan

All scenarios use WIDTH=8 and apply stimulus at negedge.

- Zero: a=0x00, b=0x00, cin=0, start for 1 cycle -> done high only in cycle 9, sum=0x00, cout=0; busy high in cycles 1..9 and low in cycle 10.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 at done. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0.
- Carry-in path: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x12, b=0x34, cin=1 -> sum=0x47, cout=0.
- Busy rejection: start a=0x10, b=0x20; in cycle 3 pulse start with a=0xFF, b=0xFF -> result is still sum=0x30, cout=0, done pulses exactly once, and no second operation starts.
- Reset mid-run: start a=0xFF, b=0xFF; assert rst in cycle 4 -> cycle 5 shows sum=0, cout=0, busy=0, and no done pulse. A subsequent start with a=0x03, b=0x04 gives sum=0x07 with done 9 cycles later.
- Back-to-back: start held high with a=0x01, b=0x01 constant -> done pulses in cycles 9, 19, 29, each with sum=0x02, cout=0; busy is low for exactly 1 cycle between operations.
